// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes engine: forward or inverse S-box over a 128-bit state,
// LANES bytes per clock, with valid/ready handshakes on both sides.
module sub_bytes_iter #(
   parameter int unsigned LANES = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] state_in,
   input  logic         inv,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] next_state,
   output logic         busy
);

   localparam int unsigned STEPS = 16 / LANES;
   localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

   if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
   end

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254; maps 0 to 0 as AES requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] base;
      logic [7:0] e;
      r    = 8'h01;
      base = a;
      e    = 8'hfe;
      for (int i = 0; i < 8; i++) begin
         if (e[i]) r = gmul(r, base);
         base = gmul(base, base);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a, input logic mode);
      logic [7:0] x;
      logic [7:0] y;
      if (!mode) begin
         x = gf_inv(a);
         return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]}
                ^ 8'h63;
      end
      y = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
      return gf_inv(y);
   endfunction

   state_e           state_q, state_d;
   logic [15:0][7:0] work_q, work_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             mode_q, mode_d;
   logic             in_ready_q, out_valid_q, busy_q;

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               work_d  = state_in;
               mode_d  = inv;
               cnt_d   = '0;
               state_d = StBusy;
            end
         end
         StBusy: begin
            // Byte 0 sits in the top byte, so byte k lives at packed index 15-k.
            for (int l = 0; l < int'(LANES); l++) begin
               logic [3:0] idx;
               idx         = 4'(15 - (int'(cnt_q) * int'(LANES) + l));
               work_d[idx] = sbox(work_q[idx], mode_q);
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(STEPS - 1)) begin
               cnt_d   = '0;
               state_d = StDone;
            end
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         work_q      <= '0;
         cnt_q       <= '0;
         mode_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         work_q      <= work_d;
         cnt_q       <= cnt_d;
         mode_q      <= mode_d;
         in_ready_q  <= (state_d == StIdle);
         out_valid_q <= (state_d == StDone);
         busy_q      <= (state_d == StBusy);
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign busy       = busy_q;
   assign next_state = work_q;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Directed bench for sub_bytes_iter: one instance per legal LANES value, FIPS-197 vectors.
module tb_sub_bytes_iter;

   logic         clk;
   logic         rst_n;
   logic         in_valid   [5];
   logic         in_ready   [5];
   logic [127:0] state_in   [5];
   logic         inv        [5];
   logic         out_valid  [5];
   logic         out_ready  [5];
   logic [127:0] next_state [5];
   logic         busy       [5];

   int checks   = 0;
   int failures = 0;

   localparam logic [127:0] V0 = 128'h00102030405060708090a0b0c0d0e0f0;
   localparam logic [127:0] S0 = 128'h63cab7040953d051cd60e0e7ba70e18c;
   localparam logic [127:0] V1 = 128'h89d810e8855ace682d1843d8cb128fe4;
   localparam logic [127:0] S1 = 128'ha761ca9b97be8b45d8ad1a611fc97369;
   localparam logic [127:0] Z  = 128'h0;
   localparam logic [127:0] F  = {16{8'hff}};
   localparam logic [127:0] I0 = {16{8'h52}};
   localparam logic [127:0] FF = {16{8'h16}};

   for (genvar g = 0; g < 5; g++) begin : g_dut
      sub_bytes_iter #(.LANES(1 << g)) u_dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .in_valid   (in_valid[g]),
         .in_ready   (in_ready[g]),
         .state_in   (state_in[g]),
         .inv        (inv[g]),
         .out_valid  (out_valid[g]),
         .out_ready  (out_ready[g]),
         .next_state (next_state[g]),
         .busy       (busy[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Accept one block on instance i, check latency and result, optionally stall in DONE.
   task automatic run_block(input int i, input logic [127:0] d, input logic m,
                            input logic [127:0] exp, input int hold);
      int lat;
      @(negedge clk);
      check("in_ready_idle", 128'(in_ready[i]), 128'd1);
      in_valid[i] = 1'b1;
      state_in[i] = d;
      inv[i]      = m;
      @(posedge clk);
      @(negedge clk);
      in_valid[i] = 1'b0;
      state_in[i] = ~d;
      inv[i]      = ~m;
      check("busy_after_accept", 128'(busy[i]), 128'd1);
      check("in_ready_busy", 128'(in_ready[i]), 128'd0);
      lat = 0;
      while (!out_valid[i] && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check("latency", 128'(lat), 128'(16 >> i));
      check("result", next_state[i], exp);
      for (int h = 0; h < hold; h++) begin
         in_valid[i] = 1'b1;
         state_in[i] = d ^ 128'h1;
         @(posedge clk);
         @(negedge clk);
         check("bp_out_valid", 128'(out_valid[i]), 128'd1);
         check("bp_result", next_state[i], exp);
         check("bp_in_ready", 128'(in_ready[i]), 128'd0);
      end
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready[i] = 1'b0;
      check("out_valid_fall", 128'(out_valid[i]), 128'd0);
      check("in_ready_after", 128'(in_ready[i]), 128'd1);
      check("busy_after", 128'(busy[i]), 128'd0);
   endtask

   initial begin
      for (int i = 0; i < 5; i++) begin
         in_valid[i]  = 1'b0;
         state_in[i]  = '0;
         inv[i]       = 1'b0;
         out_ready[i] = 1'b0;
      end
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         check("rst_in_ready", 128'(in_ready[i]), 128'd1);
         check("rst_out_valid", 128'(out_valid[i]), 128'd0);
         check("rst_next_state", next_state[i], 128'd0);
      end
      rst_n = 1'b1;

      run_block(2, V0, 1'b0, S0, 0);
      run_block(2, S0, 1'b1, V0, 0);
      run_block(2, Z, 1'b1, I0, 0);
      run_block(2, F, 1'b0, FF, 0);
      run_block(2, V1, 1'b0, S1, 5);

      // Abort in the second BUSY cycle.
      @(negedge clk);
      in_valid[2] = 1'b1;
      state_in[2] = V1;
      inv[2]      = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid[2] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", 128'(out_valid[2]), 128'd0);
      check("abort_next_state", next_state[2], 128'd0);
      check("abort_in_ready", 128'(in_ready[2]), 128'd1);
      check("abort_busy", 128'(busy[2]), 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_block(2, S1, 1'b1, V1, 0);

      for (int i = 0; i < 5; i++) begin
         if (i != 2) begin
            run_block(i, V1, 1'b0, S1, 0);
            run_block(i, S0, 1'b1, V0, 0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
